// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: control sequencer for the register-file/ALU datapath.
// Issues one register write per cycle to build a recurrence over a register
// window: r[F]=seed_a, r[F+1]=seed_b, r[F+k]=r[F+k-1] op r[F+k-2].
// Optional feature macro: FIB_SEQ_OVF_EN adds alu_cout/ovf and ends the
// sequence early on an ALU carry-out during a recurrence write.
module fib_seq_ctrl #(
    parameter int             REG_AW    = 4,
    parameter int             FIRST_REG = 1,
    parameter int             NUM_TERMS = 15,
    parameter int             ZERO_REG  = 0,
    parameter int             IMM_W     = 8,
    parameter int             OP_W      = 8,
    parameter logic [OP_W-1:0] OP_ADD   = OP_W'(8'h05),
    parameter logic [OP_W-1:0] OP_ALT   = OP_W'(8'h02)
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              mode,
    input  logic [IMM_W-1:0]  seed_a,
    input  logic [IMM_W-1:0]  seed_b,
    input  logic              run,
`ifdef FIB_SEQ_OVF_EN
    input  logic              alu_cout,
    output logic              ovf,
`endif
    output logic              selectImm,
    output logic              wr_en,
    output logic [REG_AW-1:0] loadReg,
    output logic [REG_AW-1:0] readRegA,
    output logic [REG_AW-1:0] readRegB,
    output logic [IMM_W-1:0]  Imm,
    output logic [OP_W-1:0]   op,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED_A,
        S_SEED_B,
        S_STEP,
        S_DONE
    } state_t;

    localparam logic [REG_AW-1:0] FIRST_A  = REG_AW'(FIRST_REG);
    localparam logic [REG_AW-1:0] SECOND_A = REG_AW'(FIRST_REG + 1);
    localparam logic [REG_AW-1:0] ZERO_A   = REG_AW'(ZERO_REG);
    localparam logic [REG_AW-1:0] LAST_K   = REG_AW'(NUM_TERMS - 1);

    state_t             state_q, state_d;
    logic [REG_AW-1:0]  k_q, k_d;
    logic               mode_q, mode_d;
    logic [IMM_W-1:0]   seed_a_q, seed_a_d;
    logic [IMM_W-1:0]   seed_b_q, seed_b_d;
    logic               stop_early;
`ifdef FIB_SEQ_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    // Early-termination request: carry-out of the current recurrence write
    always_comb begin
`ifdef FIB_SEQ_OVF_EN
        stop_early = alu_cout;
`else
        stop_early = 1'b0;
`endif
    end

    // Next-state logic: start acceptance, seed writes, recurrence stepping; run=0 freezes everything
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        mode_d   = mode_q;
        seed_a_d = seed_a_q;
        seed_b_d = seed_b_q;
`ifdef FIB_SEQ_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_SEED_A;
                    k_d      = '0;
                    mode_d   = mode;
                    seed_a_d = seed_a;
                    seed_b_d = seed_b;
`ifdef FIB_SEQ_OVF_EN
                    ovf_d    = 1'b0;
`endif
                end
            end
            S_SEED_A: begin
                if (run) begin
                    state_d = S_SEED_B;
                end
            end
            S_SEED_B: begin
                if (run) begin
                    if (NUM_TERMS == 2) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_STEP;
                        k_d     = REG_AW'(2);
                    end
                end
            end
            S_STEP: begin
                if (run) begin
                    if (stop_early) begin
                        state_d = S_DONE;
`ifdef FIB_SEQ_OVF_EN
                        ovf_d   = 1'b1;
`endif
                    end else if (k_q == LAST_K) begin
                        state_d = S_DONE;
                    end else begin
                        k_d = k_q + REG_AW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from state and k only; the write strobe is additionally gated by run
    always_comb begin
        selectImm = 1'b0;
        wr_en     = 1'b0;
        loadReg   = '0;
        readRegA  = '0;
        readRegB  = '0;
        Imm       = '0;
        op        = OP_ADD;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_SEED_A: begin
                busy      = 1'b1;
                selectImm = 1'b1;
                loadReg   = FIRST_A;
                readRegA  = ZERO_A;
                readRegB  = ZERO_A;
                Imm       = seed_a_q;
            end
            S_SEED_B: begin
                busy      = 1'b1;
                selectImm = 1'b1;
                loadReg   = SECOND_A;
                readRegA  = ZERO_A;
                readRegB  = ZERO_A;
                Imm       = seed_b_q;
            end
            S_STEP: begin
                busy     = 1'b1;
                loadReg  = FIRST_A + k_q;
                readRegA = FIRST_A + k_q - REG_AW'(1);
                readRegB = FIRST_A + k_q - REG_AW'(2);
                op       = mode_q ? OP_ALT : OP_ADD;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
        wr_en = run & busy;
    end

`ifdef FIB_SEQ_OVF_EN
    assign ovf = ovf_q;
`endif

    // State, index counter and start-time latches; async clear aborts any sequence
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            mode_q   <= 1'b0;
            seed_a_q <= '0;
            seed_b_q <= '0;
`ifdef FIB_SEQ_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            mode_q   <= mode_d;
            seed_a_q <= seed_a_d;
            seed_b_q <= seed_b_d;
`ifdef FIB_SEQ_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb_fib_seq_ctrl: scoreboard bench for fib_seq_ctrl.
// A reference model queues the expected write list for every accepted start;
// a monitor compares DUT outputs each cycle against the queue head.
module tb_fib_seq_ctrl;

    localparam int NT = 15;
    localparam int FR = 1;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       run = 1'b0;
    logic [7:0] seed_a = 8'd0;
    logic [7:0] seed_b = 8'd0;
    logic       selectImm, wr_en, busy, done;
    logic [3:0] loadReg, readRegA, readRegB;
    logic [7:0] Imm, op;

    logic       start2 = 1'b0;
    logic [7:0] seed_a2 = 8'd0;
    logic [7:0] seed_b2 = 8'd0;
    logic       selectImm2, wr_en2, busy2, done2;
    logic [3:0] loadReg2, readRegA2, readRegB2;
    logic [7:0] Imm2, op2;

`ifdef FIB_SEQ_OVF_EN
    logic alu_cout = 1'b0;
    logic ovf;
    logic alu_cout2 = 1'b0;
    logic ovf2;
`endif

    always #5 clk = ~clk;

    fib_seq_ctrl u_dut (
        .clk(clk), .clr_n(clr_n), .start(start), .mode(mode),
        .seed_a(seed_a), .seed_b(seed_b), .run(run),
`ifdef FIB_SEQ_OVF_EN
        .alu_cout(alu_cout), .ovf(ovf),
`endif
        .selectImm(selectImm), .wr_en(wr_en), .loadReg(loadReg),
        .readRegA(readRegA), .readRegB(readRegB), .Imm(Imm), .op(op),
        .busy(busy), .done(done)
    );

    fib_seq_ctrl #(.NUM_TERMS(2), .FIRST_REG(5)) u_dut2 (
        .clk(clk), .clr_n(clr_n), .start(start2), .mode(1'b0),
        .seed_a(seed_a2), .seed_b(seed_b2), .run(1'b1),
`ifdef FIB_SEQ_OVF_EN
        .alu_cout(alu_cout2), .ovf(ovf2),
`endif
        .selectImm(selectImm2), .wr_en(wr_en2), .loadReg(loadReg2),
        .readRegA(readRegA2), .readRegB(readRegB2), .Imm(Imm2), .op(op2),
        .busy(busy2), .done(done2)
    );

    typedef struct packed {
        logic [3:0] ld;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       sel;
        logic [7:0] imm;
        logic [7:0] op;
    } wr_t;

    wr_t exp_q[$];
    int  rem = 0;
    bit  exp_done = 1'b0;
    bit  exp_ovf = 1'b0;
    int  tests_run = 0;
    int  tests_failed = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Expected write list for one full sequence, built from the recurrence definition
    function automatic void pushSequence(input bit m, input logic [7:0] a, input logic [7:0] b);
        wr_t e;
        for (int i = 0; i < NT; i++) begin
            e.ld = 4'(FR + i);
            if (i < 2) begin
                e.sel = 1'b1;
                e.ra  = 4'd0;
                e.rb  = 4'd0;
                e.imm = (i == 0) ? a : b;
                e.op  = 8'h05;
            end else begin
                e.sel = 1'b0;
                e.ra  = 4'(FR + i - 1);
                e.rb  = 4'(FR + i - 2);
                e.imm = 8'h00;
                e.op  = m ? 8'h02 : 8'h05;
            end
            exp_q.push_back(e);
        end
    endfunction

    // Reference model advanced once per clock edge with the inputs seen at that edge
    function automatic void modelEdge(input bit s, input bit r, input bit c);
        int idx;
        if (rem > 0) begin
            if (r) begin
                idx = NT - rem;
                rem--;
`ifdef FIB_SEQ_OVF_EN
                if (c && idx >= 2) begin
                    rem = 0;
                    exp_q.delete();
                    exp_ovf = 1'b1;
                end
`else
                if (c && idx < 0) rem = 0;
`endif
                if (rem == 0) exp_done = 1'b1;
            end
        end else if (s) begin
            rem      = NT;
            exp_done = 1'b0;
            exp_ovf  = 1'b0;
            pushSequence(mode, seed_a, seed_b);
        end
    endfunction

    task automatic applyStimulus(input bit s, input bit r);
        bit c;
        start = s;
        run   = r;
        c     = 1'b0;
`ifdef FIB_SEQ_OVF_EN
        c        = ($urandom_range(0, 39) == 0);
        alu_cout = c;
`endif
        @(posedge clk);
        modelEdge(s, r, c);
        #1;
    endtask

    task automatic doReset();
        clr_n = 1'b0;
        rem = 0;
        exp_done = 1'b0;
        exp_ovf = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_loadReg", loadReg, 0);
        checkOutput("rst_readRegA", readRegA, 0);
        checkOutput("rst_readRegB", readRegB, 0);
        checkOutput("rst_Imm", Imm, 0);
        checkOutput("rst_op", op, 8'h05);
        checkOutput("rst_selectImm", selectImm, 0);
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;
    endtask

    // Issue a start then drive run/start until the model says the sequence has finished
    task automatic runSequence(input bit m, input logic [7:0] a, input logic [7:0] b,
                               input int stall_pct, input int stall_idx,
                               input bit poke_start, input int reset_idx);
        int  budget;
        bit  stalled;
        bit  r;
        bit  s;
        mode   = m;
        seed_a = a;
        seed_b = b;
        applyStimulus(1'b1, 1'b1);
        mode    = 1'($urandom_range(0, 1));
        seed_a  = 8'($urandom);
        seed_b  = 8'($urandom);
        budget  = 200;
        stalled = 1'b0;
        while (rem > 0 && budget > 0) begin
            if (reset_idx >= 0 && (NT - rem) == reset_idx) begin
                doReset();
                break;
            end
            if (!stalled && stall_idx >= 0 && (NT - rem) == stall_idx) begin
                stalled = 1'b1;
                repeat (3) applyStimulus(1'b0, 1'b0);
            end
            r = ($urandom_range(1, 100) > stall_pct);
            s = poke_start && ($urandom_range(0, 3) == 0);
            applyStimulus(s, r);
            budget--;
        end
        if (budget == 0) checkOutput("seq_timeout", rem, 0);
        applyStimulus(1'b0, 1'($urandom_range(0, 1)));
    endtask

    // Monitor: every cycle compare the DUT against the scoreboard head or the idle values
    always @(negedge clk) begin
        wr_t e;
        if (rem > 0 && exp_q.size() > 0) begin
            e = exp_q[0];
            checkOutput("busy", busy, 1);
            checkOutput("done", done, 0);
            checkOutput("loadReg", loadReg, e.ld);
            checkOutput("readRegA", readRegA, e.ra);
            checkOutput("readRegB", readRegB, e.rb);
            checkOutput("selectImm", selectImm, e.sel);
            checkOutput("Imm", Imm, e.imm);
            checkOutput("op", op, e.op);
            checkOutput("wr_en", wr_en, run);
            if (run) void'(exp_q.pop_front());
        end else begin
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_done", done, exp_done);
            checkOutput("idle_wr_en", wr_en, 0);
            checkOutput("idle_loadReg", loadReg, 0);
            checkOutput("idle_readRegA", readRegA, 0);
            checkOutput("idle_readRegB", readRegB, 0);
            checkOutput("idle_Imm", Imm, 0);
            checkOutput("idle_op", op, 8'h05);
        end
`ifdef FIB_SEQ_OVF_EN
        checkOutput("ovf", ovf, exp_ovf);
`endif
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;
        applyStimulus(1'b0, 1'b1);

        runSequence(1'b0, 8'd1, 8'd1, 0, -1, 1'b0, -1);
        runSequence(1'b0, 8'($urandom), 8'($urandom), 0, 5, 1'b0, -1);
        runSequence(1'b1, 8'($urandom), 8'($urandom), 30, -1, 1'b1, -1);
        runSequence(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 0, -1, 1'b0, 7);
        repeat (5) applyStimulus(1'b0, 1'b1);
        for (int n = 0; n < 6; n++) begin
            runSequence(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 25, -1, 1'b1, -1);
            repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
        end

        seed_a2 = 8'd7;
        seed_b2 = 8'd9;
        start2  = 1'b1;
        @(posedge clk);
        #1;
        start2  = 1'b0;
        seed_a2 = 8'd0;
        seed_b2 = 8'd0;
        @(negedge clk);
        checkOutput("n2_w1_wr_en", wr_en2, 1);
        checkOutput("n2_w1_loadReg", loadReg2, 5);
        checkOutput("n2_w1_Imm", Imm2, 7);
        checkOutput("n2_w1_selectImm", selectImm2, 1);
        @(negedge clk);
        checkOutput("n2_w2_wr_en", wr_en2, 1);
        checkOutput("n2_w2_loadReg", loadReg2, 6);
        checkOutput("n2_w2_Imm", Imm2, 9);
        @(negedge clk);
        checkOutput("n2_done", done2, 1);
        checkOutput("n2_end_wr_en", wr_en2, 0);
        checkOutput("n2_end_busy", busy2, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
